// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline memory stage.
// MEM_STAGE_ALIGN_CHECK_EN adds a misaligned flag to the MEM/WB bundle.
package mips_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } mem_state_t;

    typedef struct packed {
        logic [DATA_W-1:0]     alu_result;
        logic [DATA_W-1:0]     read_data;
        logic [REG_ADDR_W-1:0] writereg;
        logic                  reg_write;
        logic                  mem_to_reg;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        logic                  misaligned;
`endif
    } memwb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with synchronous reset and bubble insertion.
// Field set follows memwb_t (MEM_STAGE_ALIGN_CHECK_EN adds misaligned).
module mem_wb_reg
    import mips_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   bubble,
    input  memwb_t d,
    output memwb_t q
);

    // A bubble clears every field so write-back never repeats a stalled op.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (bubble) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: req/gnt data-memory bus, front-end stall, MEM/WB register.
// MEM_STAGE_ALIGN_CHECK_EN adds misaligned_W and suppresses misaligned accesses.
module mem_stage
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [DATA_W-1:0] ALUResult_M,
    input  logic [DATA_W-1:0] WriteData_M,
    input  logic [4:0]        writereg_M,
    input  logic              RegWrite_M,
    input  logic              MemtoReg_M,
    input  logic              MemWrite_M,

    output logic              stall_M,

    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata,

    output logic [DATA_W-1:0] ALUResult_W,
    output logic [DATA_W-1:0] ReadData_W,
    output logic [4:0]        writereg_W,
    output logic              RegWrite_W,
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    output logic              misaligned_W,
`endif
    output logic              MemtoReg_W
);

    mem_state_t state_q, state_d;
    logic       access;
    logic       mem_access;
    logic       is_store;
    logic       is_load;
    logic       misaligned;
    logic       complete;
    logic       busy;
    memwb_t     wb_d, wb_q;

    // Store wins when both MemtoReg and MemWrite are set.
    assign access   = MemtoReg_M | MemWrite_M;
    assign is_store = MemWrite_M;
    assign is_load  = MemtoReg_M & ~MemWrite_M;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    assign misaligned = access & (ALUResult_M[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign mem_access = access & ~misaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dmem_req = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_access) begin
                    dmem_req = 1'b1;
                    if (dmem_gnt) begin
                        if (is_store) begin
                            complete = 1'b1;
                        end else begin
                            state_d = WAIT;
                        end
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                dmem_req = 1'b1;
                if (dmem_gnt) begin
                    if (is_store) begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // rvalid is only meaningful here; elsewhere it is ignored.
                if (dmem_rvalid) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Reset overrides everything, including a late rvalid from an old access.
        if (rst) begin
            state_d  = IDLE;
            dmem_req = 1'b0;
            complete = 1'b0;
        end
    end

    assign busy    = mem_access | (state_q != IDLE);
    assign stall_M = busy & ~complete & ~rst;

    // Address, store data and we come straight from M, held stable by the stall.
    assign dmem_we    = dmem_req & is_store;
    assign dmem_addr  = {ALUResult_M[ADDR_W-1:2], 2'b00};
    assign dmem_wdata = WriteData_M;

    always_comb begin
        wb_d            = '0;
        wb_d.alu_result = ALUResult_M;
        wb_d.read_data  = (is_load && complete) ? dmem_rdata : '0;
        wb_d.writereg   = writereg_M;
        wb_d.reg_write  = RegWrite_M & ~misaligned;
        wb_d.mem_to_reg = MemtoReg_M;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        wb_d.misaligned = misaligned;
`endif
    end

    mem_wb_reg u_mem_wb_reg (
        .clk    (clk),
        .rst    (rst),
        .bubble (stall_M),
        .d      (wb_d),
        .q      (wb_q)
    );

    assign ALUResult_W = wb_q.alu_result;
    assign ReadData_W  = wb_q.read_data;
    assign writereg_W  = wb_q.writereg;
    assign RegWrite_W  = wb_q.reg_write;
    assign MemtoReg_W  = wb_q.mem_to_reg;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    assign misaligned_W = wb_q.misaligned;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, ALU pass-through, stalled store/load,
// reset during an outstanding load, and (MEM_STAGE_ALIGN_CHECK_EN) misalignment.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALUResult_M, WriteData_M;
    logic [4:0]  writereg_M;
    logic        RegWrite_M, MemtoReg_M, MemWrite_M;
    logic        stall_M;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [31:0] ALUResult_W, ReadData_W;
    logic [4:0]  writereg_W;
    logic        RegWrite_W, MemtoReg_W;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    logic        misaligned_W;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage u_dut (
        .clk         (clk),
        .rst         (rst),
        .ALUResult_M (ALUResult_M),
        .WriteData_M (WriteData_M),
        .writereg_M  (writereg_M),
        .RegWrite_M  (RegWrite_M),
        .MemtoReg_M  (MemtoReg_M),
        .MemWrite_M  (MemWrite_M),
        .stall_M     (stall_M),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .ALUResult_W (ALUResult_W),
        .ReadData_W  (ReadData_W),
        .writereg_W  (writereg_W),
        .RegWrite_W  (RegWrite_W),
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        .misaligned_W(misaligned_W),
`endif
        .MemtoReg_W  (MemtoReg_W)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; combinational checks at +3.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_m(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr,
                         input logic rw, input logic m2r, input logic mw);
        ALUResult_M = alu;
        WriteData_M = wd;
        writereg_M  = wr;
        RegWrite_M  = rw;
        MemtoReg_M  = m2r;
        MemWrite_M  = mw;
    endtask

    initial begin
        rst         = 1'b1;
        dmem_gnt    = 1'b1;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        set_m(32'h44, 32'h11, 5'd3, 1'b1, 1'b0, 1'b1);
        settle();
        check("rst_req", dmem_req, 1'b0);
        check("rst_stall", stall_M, 1'b0);
        check("rst_we", dmem_we, 1'b0);
        step();
        check("rst_alu_w", ALUResult_W, 32'h0);
        check("rst_rw_w", RegWrite_W, 1'b0);
        check("rst_m2r_w", MemtoReg_W, 1'b0);
        check("rst_wr_w", writereg_W, 5'd0);

        // ALU op passes through in one cycle
        rst      = 1'b0;
        dmem_gnt = 1'b0;
        set_m(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0);
        settle();
        check("alu_req", dmem_req, 1'b0);
        check("alu_stall", stall_M, 1'b0);
        step();
        check("alu_alu_w", ALUResult_W, 32'h1234);
        check("alu_rw_w", RegWrite_W, 1'b1);
        check("alu_wr_w", writereg_W, 5'd5);
        check("alu_rd_w", ReadData_W, 32'h0);

        // Store to 0x40, grant on the third request cycle
        set_m(32'h40, 32'hDEADBEEF, 5'd9, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            dmem_gnt = (i == 2);
            settle();
            check($sformatf("st_req%0d", i), dmem_req, 1'b1);
            check($sformatf("st_we%0d", i), dmem_we, 1'b1);
            check($sformatf("st_addr%0d", i), dmem_addr, 32'h40);
            check($sformatf("st_wdata%0d", i), dmem_wdata, 32'hDEADBEEF);
            check($sformatf("st_stall%0d", i), stall_M, (i < 2));
            step();
            if (i < 2) check($sformatf("st_bubble_alu%0d", i), ALUResult_W, 32'h0);
        end
        dmem_gnt = 1'b0;
        check("st_alu_w", ALUResult_W, 32'h40);
        check("st_rw_w", RegWrite_W, 1'b0);
        check("st_m2r_w", MemtoReg_W, 1'b0);

        // Load from 0x80, immediate grant, rvalid three cycles later
        set_m(32'h80, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0);
        dmem_gnt = 1'b1;
        settle();
        check("ld_req", dmem_req, 1'b1);
        check("ld_we", dmem_we, 1'b0);
        check("ld_addr", dmem_addr, 32'h80);
        check("ld_stall0", stall_M, 1'b1);
        step();
        dmem_gnt   = 1'b0;
        dmem_rdata = 32'h0BAD0BAD;
        for (int i = 1; i < 4; i++) begin
            dmem_rvalid = (i == 3);
            if (i == 3) dmem_rdata = 32'hCAFEF00D;
            settle();
            check($sformatf("ld_req%0d", i), dmem_req, 1'b0);
            check($sformatf("ld_stall%0d", i), stall_M, (i < 3));
            step();
            if (i < 3) check($sformatf("ld_bubble_rw%0d", i), RegWrite_W, 1'b0);
        end
        dmem_rvalid = 1'b0;
        check("ld_rd_w", ReadData_W, 32'hCAFEF00D);
        check("ld_m2r_w", MemtoReg_W, 1'b1);
        check("ld_rw_w", RegWrite_W, 1'b1);
        check("ld_wr_w", writereg_W, 5'd7);
        check("ld_alu_w", ALUResult_W, 32'h80);
        set_m(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        check("ld_rw_once", RegWrite_W, 1'b0);
        check("ld_rd_clear", ReadData_W, 32'h0);

        // Reset while waiting for load data; the late rvalid must be dropped
        set_m(32'h100, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        settle();
        check("rw_wait_stall", stall_M, 1'b1);
        rst = 1'b1;
        settle();
        check("rw_rst_stall", stall_M, 1'b0);
        check("rw_rst_req", dmem_req, 1'b0);
        step();
        rst = 1'b0;
        set_m(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h55AA55AA;
        settle();
        check("rw_post_stall", stall_M, 1'b0);
        step();
        dmem_rvalid = 1'b0;
        check("rw_rd_w", ReadData_W, 32'h0);
        check("rw_rw_w", RegWrite_W, 1'b0);
        check("rw_m2r_w", MemtoReg_W, 1'b0);
        check("rw_alu_w", ALUResult_W, 32'h0);

        // FSM back in IDLE: a store granted at once completes without stall
        set_m(32'h200, 32'h12345678, 5'd2, 1'b0, 1'b0, 1'b1);
        dmem_gnt = 1'b1;
        settle();
        check("b2b_req", dmem_req, 1'b1);
        check("b2b_stall", stall_M, 1'b0);
        step();
        check("b2b_alu_w", ALUResult_W, 32'h200);
        dmem_gnt = 1'b0;
        set_m(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();

`ifdef MEM_STAGE_ALIGN_CHECK_EN
        set_m(32'h82, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0);
        settle();
        check("mis_req", dmem_req, 1'b0);
        check("mis_stall", stall_M, 1'b0);
        step();
        check("mis_flag_w", misaligned_W, 1'b1);
        check("mis_rw_w", RegWrite_W, 1'b0);
        set_m(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        check("mis_flag_clear", misaligned_W, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the pipelined MIPS core, directly downstream of the EXE/MEM pipeline register. Consumes the M-stage bundle, drives a request/grant data-memory bus for loads and stores, stalls the front of the pipeline while an access is outstanding, and registers the result into the MEM/WB boundary (`_W` outputs) for write-back.

## Interface
- `ADDR_W`, default 32: data-memory address width.
- `DATA_W`, default 32: data word width.
- `clk  in  1`: clock, rising edge.
- `rst  in  1`: reset, synchronous, active-high.
- `ALUResult_M  in  DATA_W`: effective address, or ALU result for non-memory ops.
- `WriteData_M  in  DATA_W`: store data.
- `writereg_M  in  5`: destination register.
- `RegWrite_M, MemtoReg_M, MemWrite_M  in  1 each`: control. MemtoReg marks a load, MemWrite a store.
- `stall_M  out  1`: holds the EXE/MEM register and everything upstream.
- `dmem_req  out  1`: memory request valid.
- `dmem_we  out  1`: 1 = store.
- `dmem_addr  out  ADDR_W`: word address, `{ALUResult_M[ADDR_W-1:2],2'b00}`.
- `dmem_wdata  out  DATA_W`: store data.
- `dmem_gnt  in  1`: request accepted this cycle.
- `dmem_rvalid  in  1`: load data valid.
- `dmem_rdata  in  DATA_W`: load data.
- `ALUResult_W, ReadData_W  out  DATA_W`; `writereg_W  out  5`; `RegWrite_W, MemtoReg_W  out  1`: MEM/WB bundle.

## Operation
- Access = MemtoReg_M | MemWrite_M. If both are set, the access is treated as a store. RegWrite propagates unchanged.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: non-access ops pass through, and the W bundle loads next edge. On an access, `dmem_req` is driven combinationally.
    - Store with gnt: completes.
    - Load with gnt: go to WAIT.
    - No gnt: go to REQ.
  - REQ: `dmem_req` held with stable addr, we, and wdata until gnt.
    - Store with gnt: completes, go to IDLE.
    - Load with gnt: go to WAIT.
  - WAIT: `dmem_req` = 0. On rvalid the load completes and the FSM goes to IDLE.
- `dmem_rvalid` is only honoured in WAIT. It arrives no earlier than the cycle after gnt, and is ignored in IDLE and REQ.
- `stall_M` = access present & ~complete_this_cycle. It is combinational from gnt and rvalid.
- W bundle update:
  - Completion or non-access op: ALUResult_W <= ALUResult_M; ReadData_W <= dmem_rdata (load) or 0; writereg, RegWrite, and MemtoReg copied from M.
  - While stalled: a bubble is loaded (RegWrite_W = 0, MemtoReg_W = 0, other fields 0), so write-back never repeats.
- Reset: FSM to IDLE, and all `_W` outputs 0. `dmem_req`, `stall_M`, and `dmem_we` are 0 in the reset cycle regardless of inputs. An rvalid from an access that was in flight across reset is dropped.

## Timing
- Non-memory op: 1-cycle latency, M to W.
- Store granted in IDLE: 1 cycle, no stall.
- Store granted after N wait cycles: N stall cycles.
- Load with gnt at cycle t and rvalid at t+k (k ≥ 1): `stall_M` is high from the access cycle through t+k-1. The W bundle with data is valid after edge t+k.
- Back-to-back accesses: the next access may issue in the cycle after completion, since the FSM is back in IDLE.
- No combinational path from `dmem_rdata` to any output except through the W register.

## Configuration
- `MEM_STAGE_ALIGN_CHECK_EN` defined:
  - Adds output `misaligned_W` (1 bit, reset 0).
  - An access with `ALUResult_M[1:0] != 0` issues no `dmem_req` and completes in 1 cycle.
  - The W bundle for that access has RegWrite_W = 0 and `misaligned_W` = 1. `misaligned_W` is 0 for every other W update.
- Undefined: the port is absent. Low address bits are silently truncated and the access proceeds.

## Structure
- Package `mips_pkg`:
  - `mem_state_t` enum (IDLE, REQ, WAIT).
  - Constants `DATA_W` and `REG_ADDR_W` = 5.
  - Packed struct `memwb_t` for the W bundle.
- One sub-module, `mem_wb_reg`: MEM/WB register with synchronous reset and a bubble-insert input. The FSM and bus logic stay in `mem_stage`.

## Test plan
- Reset with RegWrite_M = 1 and MemWrite_M = 1 asserted -> all `_W` outputs 0, and `dmem_req` = 0 and `stall_M` = 0 during reset.
- ALU op (ALUResult_M = 0x1234, writereg_M = 5, RegWrite_M = 1), no access -> next cycle ALUResult_W = 0x1234, RegWrite_W = 1, no req, no stall.
- Store to 0x40, data 0xDEADBEEF, gnt after 2 cycles -> req held 3 cycles with stable addr and data, `stall_M` high 2 cycles, then W bubble-free with RegWrite_W = 0.
- Load from 0x80: gnt immediate, rvalid 3 cycles later with 0xCAFEF00D -> `stall_M` high 3 cycles, then ReadData_W = 0xCAFEF00D with MemtoReg_W = 1, and RegWrite_W = 1 for exactly one cycle.
- `rst` asserted in WAIT, then rvalid arrives -> FSM IDLE, rvalid ignored, W outputs remain 0.
- With `MEM_STAGE_ALIGN_CHECK_EN`, load from 0x82 -> no `dmem_req`, `misaligned_W` = 1 and RegWrite_W = 0 next cycle, no stall.
